// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: ROM address/data, decode valid/ready handshake and redirect.
// master = the fetch queue, slave = the ROM/decode environment around it.
interface inst_fetch_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              inst_valid;
   logic [31:0]       inst_data;
   logic [31:0]       inst_pc;
   logic              inst_ready;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic [15:0]       fetch_count;

   modport master (
      output rom_addr, inst_valid, inst_data, inst_pc, fetch_count,
      input  rom_data, inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  rom_addr, inst_valid, inst_data, inst_pc, fetch_count,
      output rom_data, inst_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch: owns the fetch PC, reads the combinational ROM and buffers
// {pc, instr} in a small FIFO toward decode; redirects flush and refetch.
//
//   state   | meaning
//   S_FILL  | queue has room, fetching one word per cycle
//   S_FULL  | count == DEPTH, fetch stalled until decode pops
//   S_FLUSH | one cycle after a redirect; queue empty, fetching from new PC
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int          ADDR_W   = 12,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   inst_fetch_if.master bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_FULL  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [31:0]      fetch_pc;
   logic [31:0]      entry_pc    [DEPTH];
   logic [31:0]      entry_instr [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [1:0]       state;
   logic [15:0]      fetch_count;
   logic             push;
   logic             pop;

   assign bus.rom_addr    = fetch_pc[ADDR_W-1:0];
   assign bus.inst_valid  = (count != '0);
   assign bus.inst_data   = entry_instr[rd_ptr];
   assign bus.inst_pc     = entry_pc[rd_ptr];
   assign bus.fetch_count = fetch_count;

   // S_FULL tracks count == DEPTH exactly, so it alone gates the fetch.
   assign pop  = bus.inst_valid & bus.inst_ready;
   assign push = ~bus.redirect_valid & (state != S_FULL);

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (pop && !push)
         count_next = count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         fetch_count <= '0;
         state       <= S_FILL;
         for (int i = 0; i < DEPTH; i++) begin
            entry_pc[i]    <= '0;
            entry_instr[i] <= '0;
         end
      end else if (bus.redirect_valid) begin
         // A same-cycle pop is still taken by decode; the queue is emptied regardless.
         fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         state    <= S_FLUSH;
      end else begin
         if (push) begin
            entry_pc[wr_ptr]    <= fetch_pc;
            entry_instr[wr_ptr] <= bus.rom_data;
            wr_ptr              <= wr_ptr + PTR_W'(1);
            fetch_pc            <= fetch_pc + 32'd4;
            fetch_count         <= fetch_count + 16'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         state <= (count_next == CNT_W'(DEPTH)) ? S_FULL : S_FILL;
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic, all checked
// against a queue-based model of fetch/redirect/reset behaviour.
module tb_inst_fetch_queue;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int          ADDR_W   = 12;
   localparam int          DEPTH    = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   inst_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   inst_fetch_queue #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
      return {~a, 8'h5A, a} ^ 32'h1357_0000;
   endfunction

   assign bus.rom_data = rom_word(bus.rom_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic [15:0] m_cnt;
   bit          m_known;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
      bit full;
      rst                = r;
      bus.inst_ready     = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
      if (m_known) begin
         check("model_valid", {31'd0, bus.inst_valid}, {31'd0, mq.size() != 0});
         check("model_rom_addr", {20'd0, bus.rom_addr}, {20'd0, m_pc[ADDR_W-1:0]});
         check("model_fetch_count", {16'd0, bus.fetch_count}, {16'd0, m_cnt});
         if (mq.size() != 0) begin
            check("model_pc", bus.inst_pc, mq[0][63:32]);
            check("model_data", bus.inst_data, mq[0][31:0]);
         end
      end
      @(posedge clk);
      if (r) begin
         mq.delete();
         m_pc    = RESET_PC;
         m_cnt   = 16'd0;
         m_known = 1'b1;
      end else if (rv) begin
         mq.delete();
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         full = (mq.size() == DEPTH);
         if (mq.size() != 0 && rdy)
            void'(mq.pop_front());
         if (!full) begin
            mq.push_back({m_pc, rom_word(m_pc[ADDR_W-1:0])});
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 16'd1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rpc;
      n_checks           = 0;
      n_fail             = 0;
      m_known            = 1'b0;
      rst                = 1'b1;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;

      // T1 reset
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check("t1_valid0", {31'd0, bus.inst_valid}, 32'd0);
      check("t1_data0", bus.inst_data, 32'd0);
      check("t1_pc0", bus.inst_pc, 32'd0);
      check("t1_rom_addr", {20'd0, bus.rom_addr}, 32'h000);
      check("t1_count0", {16'd0, bus.fetch_count}, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("t1_valid1", {31'd0, bus.inst_valid}, 32'd1);
      check("t1_pc", bus.inst_pc, 32'h0040_0000);
      check("t1_data", bus.inst_data, rom_word(12'h000));
      check("t1_count1", {16'd0, bus.fetch_count}, 32'd1);

      // T2 streaming
      for (int i = 0; i < 6; i++) begin
         check("t2_valid", {31'd0, bus.inst_valid}, 32'd1);
         check("t2_pc", bus.inst_pc, 32'h0040_0000 + 32'(4 * i));
         check("t2_data", bus.inst_data, rom_word(12'(4 * i)));
         cycle(1'b0, 1'b1, 1'b0, 32'd0);
      end

      // T3 backpressure
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
      check("t3_fetch_count", {16'd0, bus.fetch_count}, 32'd2);
      check("t3_rom_addr", {20'd0, bus.rom_addr}, 32'h008);
      for (int i = 0; i < 3; i++) begin
         check("t3_drain_pc", bus.inst_pc, 32'h0040_0000 + 32'(4 * i));
         cycle(1'b0, 1'b1, 1'b0, 32'd0);
      end

      // T4 redirect while full
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      check("t4_full_stall", {20'd0, bus.rom_addr}, 32'h014);
      cycle(1'b0, 1'b0, 1'b1, 32'h0040_0013);
      check("t4_valid0", {31'd0, bus.inst_valid}, 32'd0);
      check("t4_rom_addr", {20'd0, bus.rom_addr}, 32'h010);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("t4_valid1", {31'd0, bus.inst_valid}, 32'd1);
      check("t4_pc", bus.inst_pc, 32'h0040_0010);

      // T5 reset beats redirect with a full queue
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b1, 1'b1, 32'h1234_5678);
      check("t5_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("t5_rom_addr", {20'd0, bus.rom_addr}, 32'h000);
      check("t5_fetch_count", {16'd0, bus.fetch_count}, 32'd0);
      check("t5_pc", bus.inst_pc, 32'd0);

      // T6 PC wrap
      cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      check("t6_rom_addr_hi", {20'd0, bus.rom_addr}, 32'hFFC);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("t6_pc_hi", bus.inst_pc, 32'hFFFF_FFFC);
      check("t6_rom_addr_lo", {20'd0, bus.rom_addr}, 32'h000);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      check("t6_pc_lo", bus.inst_pc, 32'h0000_0000);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : $urandom;
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) == 0),
               rpc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
